// File: rtl/countdown_ctrl.sv
// countdown_ctrl: MM:SS countdown sequencer that tracks set/run/pause/done, holds the BCD time and drives the blink mask.
module countdown_ctrl #(
    parameter int TICK_DIV  = 50000000,
    parameter int BLINK_DIV = 12500000,
    parameter int PRE_MIN   = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_start,
    input  logic       btn_set,
    input  logic       btn_inc,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic [3:0] blank_mask,
    output logic [2:0] state,
    output logic       done
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SET_MIN = 3'd1,
        SET_SEC = 3'd2,
        RUN     = 3'd3,
        PAUSE   = 3'd4,
        DONE    = 3'd5
    } state_t;

    localparam int TW = $clog2(TICK_DIV);
    localparam int BW = $clog2(BLINK_DIV);
    localparam logic [15:0] PRE = {4'(PRE_MIN / 10), 4'(PRE_MIN % 10), 8'h00};

    state_t        cur, nxt;
    logic [15:0]   tm, tm_n, rl, rl_n;
    logic [TW-1:0] pc;
    logic [BW-1:0] bc;
    logic [2:0]    btn_q, btn_qq, pulse;
    logic [3:0]    mask_n;
    logic          ph, ph_n, pc_clr, tick, p_start, p_set, p_inc;

    function automatic logic [7:0] inc59(input logic [7:0] v);
        return v[3:0] == 4'd9 ? (v[7:4] == 4'd5 ? 8'h00 : {v[7:4] + 4'd1, 4'd0})
                              : {v[7:4], v[3:0] + 4'd1};
    endfunction

    // Per-digit BCD borrow chain; callers never pass 00:00.
    function automatic logic [15:0] dec_time(input logic [15:0] t);
        logic b0, b1, b2;
        b0 = t[3:0] == 4'd0;
        b1 = b0 && t[7:4] == 4'd0;
        b2 = b1 && t[11:8] == 4'd0;
        return {b2 ? t[15:12] - 4'd1 : t[15:12],
                b1 ? (b2 ? 4'd9 : t[11:8] - 4'd1) : t[11:8],
                b0 ? (b1 ? 4'd5 : t[7:4] - 4'd1) : t[7:4],
                b0 ? 4'd9 : t[3:0] - 4'd1};
    endfunction

    assign pulse   = btn_q & ~btn_qq;
    assign p_start = pulse[2];
    assign p_set   = pulse[1];
    assign p_inc   = pulse[0];
    assign tick    = cur == RUN && pc == TW'(TICK_DIV - 1);
    assign ph_n    = ph ^ (bc == BW'(BLINK_DIV - 1));
    assign {min_tens, min_ones, sec_tens, sec_ones} = tm;
    assign state   = cur;

    always_comb begin
        nxt    = cur;
        tm_n   = tm;
        rl_n   = rl;
        pc_clr = 1'b0;
        case (cur)
            IDLE: begin
                if (p_start) begin
                    if (tm != 16'h0000) begin
                        nxt    = RUN;
                        rl_n   = tm;
                        pc_clr = 1'b1;
                    end
                end else if (p_set) nxt = SET_MIN;
            end
            SET_MIN: begin
                if (p_inc) tm_n[15:8] = inc59(tm[15:8]);
                if (p_set) nxt = SET_SEC;
            end
            SET_SEC: begin
                if (p_inc) tm_n[7:0] = inc59(tm[7:0]);
                if (p_set) nxt = IDLE;
            end
            RUN: begin
                if (p_start) nxt = PAUSE;
                if (tick) tm_n = dec_time(tm);
                if (tick && tm == 16'h0001) nxt = DONE;
            end
            PAUSE: nxt = p_start ? RUN : p_set ? IDLE : PAUSE;
            DONE: begin
                if (p_start || p_set) begin
                    tm_n = rl;
                    nxt  = IDLE;
                end
            end
            default: nxt = IDLE;
        endcase
    end

    always_comb
        mask_n = nxt == SET_MIN ? {ph_n, ph_n, 2'b00} :
                 nxt == SET_SEC ? {2'b00, ph_n, ph_n} :
                 nxt == DONE    ? {4{ph_n}} : 4'b0000;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cur        <= IDLE;
            tm         <= PRE;
            rl         <= PRE;
            pc         <= '0;
            bc         <= '0;
            ph         <= 1'b0;
            btn_q      <= '0;
            btn_qq     <= '0;
            blank_mask <= '0;
            done       <= 1'b0;
        end else begin
            cur        <= nxt;
            tm         <= tm_n;
            rl         <= rl_n;
            pc         <= pc_clr ? '0 : cur == RUN ? (tick ? '0 : pc + TW'(1)) : pc;
            bc         <= bc == BW'(BLINK_DIV - 1) ? '0 : bc + BW'(1);
            ph         <= ph_n;
            btn_q      <= {btn_start, btn_set, btn_inc};
            btn_qq     <= btn_q;
            blank_mask <= mask_n;
            done       <= nxt == DONE;
        end
    end
endmodule

// File: doc/countdown_ctrl.md
Name: countdown_ctrl

Overview:
Sequencing controller for the MM:SS countdown display. It owns the user-facing timer state machine: set mode, run, pause and done. It holds the BCD time value and generates the 1 s tick from the system clock. Its BCD digits and blank mask feed the existing multiplexed 7-segment scan/decode datapath, which handles the dash digit and segment encoding itself.

Parameters:
TICK_DIV, 50000000, clk cycles per 1 s countdown tick (min 2)
BLINK_DIV, 12500000, clk cycles per blink phase toggle (min 2)
PRE_MIN, 10, minutes value loaded at reset (0..59)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-low
btn_start  in  1  start/pause button, active-high level, already debounced
btn_set  in  1  set/abort button, active-high level, already debounced
btn_inc  in  1  increment button, active-high level, already debounced
min_tens  out  4  BCD minutes tens (0..5)
min_ones  out  4  BCD minutes ones (0..9)
sec_tens  out  4  BCD seconds tens (0..5)
sec_ones  out  4  BCD seconds ones (0..9)
blank_mask  out  4  per-digit blank request {min_tens,min_ones,sec_tens,sec_ones}, 1 = blank
state  out  3  IDLE=0, SET_MIN=1, SET_SEC=2, RUN=3, PAUSE=4, DONE=5
done  out  1  high while state==DONE

Behaviour:
- Reset when rst==0 at a clk edge, regardless of state:
  - state=IDLE; time=PRE_MIN:00; reload register=PRE_MIN:00.
  - Prescaler, blink counter and blink phase = 0; button history registers = 0.
  - blank_mask=0000; done=0.
- Button pulses:
  - Each button is registered once. A one-cycle pulse is generated on the 0->1 transition of the registered value.
  - A press takes effect on the state/time registers 2 edges after the input rises.
- Priority when start and set pulse in the same cycle:
  - IDLE, RUN, PAUSE: start wins, set is dropped.
  - SET_MIN, SET_SEC: start is ignored, set is processed.
- Prescaler:
  - Counts only in RUN. Holds its value in PAUSE. Cleared on the IDLE->RUN transition.
  - Counts 0..TICK_DIV-1, then wraps to 0. tick=1 for the single cycle in which it wraps.
- Time arithmetic, BCD per digit:
  - Seconds decrement: ones 0 -> 9 with tens borrow; tens 0 -> 5 with minute borrow.
  - Minutes decrement borrows similarly; 00:00 never decrements.
  - Increment in set mode: 59 -> 00 wrap, no carry between fields.
- IDLE:
  - start with time != 00:00: reload <= time, prescaler <= 0, go RUN.
  - start with time == 00:00: ignored.
  - set: go SET_MIN.
- SET_MIN:
  - inc: minutes +1 (59 wraps to 00).
  - set: go SET_SEC.
- SET_SEC:
  - inc: seconds +1 (59 wraps to 00).
  - set: go IDLE.
- RUN:
  - tick: decrement time. If the pre-decrement value is 00:01, time becomes 00:00 and state goes DONE on the same edge.
  - start: go PAUSE. If start and tick coincide, the decrement still occurs.
  - set, inc: ignored.
- PAUSE:
  - start: go RUN with the prescaler retained.
  - set: go IDLE with time retained (abort).
  - inc: ignored.
- DONE:
  - done=1, time=00:00.
  - start or set: time <= reload, go IDLE.
  - inc: ignored.
- Blink:
  - Blink counter is free-running 0..BLINK_DIV-1. The phase toggles on each wrap.
  - blank_mask = {phase,phase,0,0} in SET_MIN; {0,0,phase,phase} in SET_SEC; {4{phase}} in DONE; 0000 otherwise.
- Outputs: all registered. They reflect the new state/time on the edge that changes them, with no extra latency.
- Illegal state codes (6, 7): go IDLE next edge with time unchanged.

Test Plan:
- Reset with TICK_DIV=4, BLINK_DIV=2, PRE_MIN=10 -> outputs 1,0,0,0; state=0; done=0; blank_mask=0000. Hold state, press start -> state=3 two edges later. First decrement to 09:59 occurs 4 cycles after RUN entry.
- Set mode: from IDLE press set, inc×3 -> minutes 13; press set, inc×61 -> seconds 01 (wrap at 59); press set -> state=0, time 13:01. blank_mask toggles 1100 in SET_MIN and 0011 in SET_SEC every 2 cycles.
- Countdown to done: load 00:02, start -> 00:01 -> 00:00 on successive ticks, state=5 and done=1 on the 00:00 edge. blank_mask toggles 1111/0000. Press set -> time 00:02, state=0.
- Pause/resume: in RUN press start 2 cycles after a tick -> state=4, time frozen for 100 cycles. Press start -> next decrement occurs exactly 2 cycles after re-entering RUN, since the prescaler is retained.
- Boundary/priority: at 00:00 in IDLE press start -> stays 0. Start and set on the same edge in IDLE -> RUN. Start and tick on the same edge -> PAUSE with decremented time. Borrow check: 10:00 -> 09:59.
- Reset mid-operation: drive rst=0 for 1 edge while in RUN at 03:27 with a mid-count prescaler -> next edge state=0, time 10:00, prescaler 0. With rst=0 held, button presses are ignored.
